// File: rtl/shared_kes_syndrome_arbiter_pkg.sv
// Shared definitions for the KES syndrome arbiter slice.
//
// Provides:
//   - width derivation helpers for the chunk index, the channel index and
//     the packed syndrome vector
//   - the arbiter state type
//   - the bit layout of one FIFO entry, LSB first:
//       [0]                          last chunk of page
//       [1]                          decode needed
//       [2 +: ChunkWidth]            chunk number
//       [2+ChunkWidth +: SW]         syndromes (zero when no decode needed)
package shared_kes_syndrome_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int LastPos   = 0;
    localparam int DecodePos = 1;
    localparam int ChunkLsb  = 2;

    // A one-value index still needs one bit of storage.
    function automatic int chunk_width(input int multi);
        return (multi <= 2) ? 1 : $clog2(multi);
    endfunction

    function automatic int channel_width(input int channel);
        return (channel <= 2) ? 1 : $clog2(channel);
    endfunction

    function automatic int syndrome_width(input int gf_degree, input int syndromes);
        return gf_degree * syndromes;
    endfunction

    function automatic int entry_width(input int sw, input int cw);
        return sw + cw + ChunkLsb;
    endfunction

endpackage

// File: rtl/shared_kes_channel_fifo.sv
// Per-channel synchronous FIFO holding chunk entries awaiting the KES.
//
// Ports:
//   iClock      clock
//   iReset      synchronous, active-high; flushes pointers and count
//   write       push request; ignored while full
//   write_data  entry to push
//   pop         pop request; ignored while empty
//   head        entry at the read pointer (valid when !empty)
//   full        count == Depth
//   empty       count == 0
//
// Depth must be a power of two so the pointers wrap naturally.
module shared_kes_channel_fifo #(
    parameter int Depth      = 4,
    parameter int EntryWidth = 8
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  write,
    input  logic [EntryWidth-1:0] write_data,
    input  logic                  pop,
    output logic [EntryWidth-1:0] head,
    output logic                  full,
    output logic                  empty
);

    localparam int PtrW   = $clog2(Depth);
    localparam int CountW = $clog2(Depth + 1);

    logic [EntryWidth-1:0] mem [Depth];
    logic [PtrW-1:0]       wr_ptr;
    logic [PtrW-1:0]       rd_ptr;
    logic [CountW-1:0]     count;
    logic                  do_write;
    logic                  do_pop;

    // Acceptance depends only on the registered full flag, so a full FIFO
    // never takes a write even when it is popped in the same cycle.
    assign do_write = write && !full;
    assign do_pop   = pop && !empty;

    assign full  = (count == CountW'(Depth));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge iClock) begin
        if (iReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge iClock) begin
        if (do_write) begin
            mem[wr_ptr] <= write_data;
        end
    end

endmodule

// File: rtl/shared_kes_syndrome_arbiter.sv
// Shares one key-equation-solver (KES) engine between several NAND channels.
//
// Each channel pushes chunk entries (syndromes, chunk index, decode flag,
// last-of-page flag) into its own FIFO. A page-locked round-robin arbiter
// picks a channel, then serves only that channel until the entry flagged as
// last is popped. Popped entries are registered and presented for one cycle
// with oExecuteKES.
//
// Ports:
//   iClock, iReset          clock, synchronous active-high reset
//   iSyndromeValid[c]       channel c presents an entry
//   oSyndromeReady[c]       channel c FIFO not full
//   iSyndromes              Channel x SW packed syndromes
//   iChunkNumber            Channel x ChunkWidth chunk index
//   iDecodeNeeded[c]        entry has errors (0 = forward only)
//   iLastChunk[c]           entry closes the page
//   iKESAvailable           KES can take an entry this cycle
//   oExecuteKES             one-cycle issue strobe
//   oSyndromes             issued syndromes (zero for forward-only entries)
//   oErroredChunkNumber     issued chunk index
//   oDataForwarding         issued entry needs no decode
//   oLastChunk              issued entry closes the page
//   oChannelSel             channel of the issued entry
//   oOverflow               sticky: a channel offered an entry while full
module shared_kes_syndrome_arbiter
    import shared_kes_syndrome_arbiter_pkg::*;
#(
    parameter  int Channel           = 4,
    parameter  int Multi             = 2,
    parameter  int GaloisFieldDegree = 12,
    parameter  int Syndromes         = 27,
    parameter  int Depth             = 4,
    localparam int ChunkWidth        = chunk_width(Multi),
    localparam int ChannelWidth      = channel_width(Channel),
    localparam int SW                = syndrome_width(GaloisFieldDegree, Syndromes)
) (
    input  logic                          iClock,
    input  logic                          iReset,
    input  logic [Channel-1:0]            iSyndromeValid,
    output logic [Channel-1:0]            oSyndromeReady,
    input  logic [Channel*SW-1:0]         iSyndromes,
    input  logic [Channel*ChunkWidth-1:0] iChunkNumber,
    input  logic [Channel-1:0]            iDecodeNeeded,
    input  logic [Channel-1:0]            iLastChunk,
    input  logic                          iKESAvailable,
    output logic                          oExecuteKES,
    output logic [SW-1:0]                 oSyndromes,
    output logic [ChunkWidth-1:0]         oErroredChunkNumber,
    output logic                          oDataForwarding,
    output logic                          oLastChunk,
    output logic [ChannelWidth-1:0]       oChannelSel,
    output logic                          oOverflow
);

    localparam int EW = entry_width(SW, ChunkWidth);

    logic [EW-1:0]           head [Channel];
    logic [Channel-1:0]      full;
    logic [Channel-1:0]      empty;
    logic [Channel-1:0]      pop_vec;

    arb_state_t              state;
    arb_state_t              state_next;
    logic [ChannelWidth-1:0] grant;
    logic [ChannelWidth-1:0] grant_next;
    logic [ChannelWidth-1:0] rr_ptr;
    logic [ChannelWidth-1:0] rr_ptr_next;
    logic [ChannelWidth-1:0] pick;
    logic                    pick_found;
    logic [ChannelWidth-1:0] sel_p0;
    logic                    have_grant;
    logic                    pop_p0;
    logic [EW-1:0]           head_p0;

    logic                    vld_p1;
    logic [SW-1:0]           syndromes_p1;
    logic [ChunkWidth-1:0]   chunk_p1;
    logic                    forward_p1;
    logic                    last_p1;
    logic [ChannelWidth-1:0] channel_p1;
    logic                    overflow;

    // ---------------- channel FIFOs ----------------
    for (genvar c = 0; c < Channel; c++) begin : g_channel
        logic [SW-1:0] syn_masked;
        logic [EW-1:0] wr_entry;

        // Forward-only entries carry no syndromes, so the KES sees zeros.
        assign syn_masked = iDecodeNeeded[c] ? iSyndromes[c*SW +: SW] : '0;
        assign wr_entry   = {syn_masked,
                             iChunkNumber[c*ChunkWidth +: ChunkWidth],
                             iDecodeNeeded[c],
                             iLastChunk[c]};

        shared_kes_channel_fifo #(
            .Depth      (Depth),
            .EntryWidth (EW)
        ) u_fifo (
            .iClock     (iClock),
            .iReset     (iReset),
            .write      (iSyndromeValid[c]),
            .write_data (wr_entry),
            .pop        (pop_vec[c]),
            .head       (head[c]),
            .full       (full[c]),
            .empty      (empty[c])
        );
    end

    assign oSyndromeReady = ~full;

    // Round-robin search starting one past the last channel whose page
    // completed.
    always_comb begin
        logic [ChannelWidth-1:0] idx;
        pick       = '0;
        pick_found = 1'b0;
        idx        = '0;
        for (int i = 1; i <= Channel; i++) begin
            idx = ChannelWidth'((int'(rr_ptr) + i) % Channel);
            if (!pick_found && !empty[idx]) begin
                pick       = idx;
                pick_found = 1'b1;
            end
        end
    end

    // ---------------- stage p0: arbitration and pop ----------------
    // In IDLE the freshly picked channel is served in the same cycle, which
    // keeps write-to-issue latency at two cycles and lets a new page start
    // right after a one-entry page without a bubble.
    always_comb begin
        sel_p0      = (state == LOCKED) ? grant : pick;
        have_grant  = (state == LOCKED) || pick_found;
        head_p0     = head[sel_p0];
        pop_p0      = have_grant && iKESAvailable && !empty[sel_p0];
        pop_vec     = '0;
        state_next  = state;
        grant_next  = grant;
        rr_ptr_next = rr_ptr;

        if (pop_p0) begin
            pop_vec[sel_p0] = 1'b1;
        end

        if (have_grant) begin
            if (pop_p0 && head_p0[LastPos]) begin
                state_next  = IDLE;
                rr_ptr_next = sel_p0;
            end else begin
                state_next  = LOCKED;
                grant_next  = sel_p0;
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= ChannelWidth'(Channel - 1);
        end else begin
            state  <= state_next;
            grant  <= grant_next;
            rr_ptr <= rr_ptr_next;
        end
    end

    // ---------------- stage p1: registered issue ----------------
    always_ff @(posedge iClock) begin
        if (iReset) begin
            vld_p1       <= 1'b0;
            syndromes_p1 <= '0;
            chunk_p1     <= '0;
            forward_p1   <= 1'b0;
            last_p1      <= 1'b0;
            channel_p1   <= '0;
            overflow     <= 1'b0;
        end else begin
            vld_p1 <= pop_p0;
            if (pop_p0) begin
                syndromes_p1 <= head_p0[ChunkLsb+ChunkWidth +: SW];
                chunk_p1     <= head_p0[ChunkLsb +: ChunkWidth];
                forward_p1   <= !head_p0[DecodePos];
                last_p1      <= head_p0[LastPos];
                channel_p1   <= sel_p0;
            end
            if (|(iSyndromeValid & full)) begin
                overflow <= 1'b1;
            end
        end
    end

    assign oExecuteKES         = vld_p1;
    assign oSyndromes          = syndromes_p1;
    assign oErroredChunkNumber = chunk_p1;
    assign oDataForwarding     = forward_p1;
    assign oLastChunk          = last_p1;
    assign oChannelSel         = channel_p1;
    assign oOverflow           = overflow;

endmodule

// File: tb/tb_shared_kes_syndrome_arbiter.sv
// Testbench for shared_kes_syndrome_arbiter with default parameters.
// A queue-based reference model tracks per-channel pages and predicts the
// issued entry; a compare process checks every output on each falling edge.
// Directed scenarios add literal expectations at specific cycles.
module tb_shared_kes_syndrome_arbiter;

    localparam int CH    = 4;
    localparam int NS    = 27;
    localparam int DEPTH = 4;
    localparam int SW    = 12 * NS;
    localparam int CW    = 1;
    localparam int CHW   = 2;

    logic              clk;
    logic              rst;
    logic [CH-1:0]     syn_valid;
    logic [CH-1:0]     syn_ready;
    logic [CH*SW-1:0]  syn_in;
    logic [CH*CW-1:0]  chunk_in;
    logic [CH-1:0]     dec_in;
    logic [CH-1:0]     last_in;
    logic              kes_avail;
    logic              exec;
    logic [SW-1:0]     syn_out;
    logic [CW-1:0]     chunk_out;
    logic              fwd_out;
    logic              last_out;
    logic [CHW-1:0]    sel_out;
    logic              ovf;

    shared_kes_syndrome_arbiter #(
        .Channel           (CH),
        .Multi             (2),
        .GaloisFieldDegree (12),
        .Syndromes         (NS),
        .Depth             (DEPTH)
    ) dut (
        .iClock              (clk),
        .iReset              (rst),
        .iSyndromeValid      (syn_valid),
        .oSyndromeReady      (syn_ready),
        .iSyndromes          (syn_in),
        .iChunkNumber        (chunk_in),
        .iDecodeNeeded       (dec_in),
        .iLastChunk          (last_in),
        .iKESAvailable       (kes_avail),
        .oExecuteKES         (exec),
        .oSyndromes          (syn_out),
        .oErroredChunkNumber (chunk_out),
        .oDataForwarding     (fwd_out),
        .oLastChunk          (last_out),
        .oChannelSel         (sel_out),
        .oOverflow           (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [SW-1:0] syn;
        logic [CW-1:0] chunk;
        logic          dec;
        logic          last;
    } m_ent_t;

    m_ent_t         q [CH][$];
    int             owner;
    int             rr;
    bit             started = 0;
    bit             m_exec;
    logic [SW-1:0]  m_syn;
    logic [CW-1:0]  m_chunk;
    bit             m_fwd;
    bit             m_last;
    logic [CHW-1:0] m_sel;
    bit             m_ovf;
    bit             acc [CH];
    int             pick;
    bit             popd;
    m_ent_t         e;
    m_ent_t         ne;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int c = 0; c < CH; c++) q[c].delete();
                owner   = -1;
                rr      = CH - 1;
                m_exec  = 0;
                m_syn   = '0;
                m_chunk = '0;
                m_fwd   = 0;
                m_last  = 0;
                m_sel   = '0;
                m_ovf   = 0;
                started = 1;
            end else begin
                for (int c = 0; c < CH; c++) begin
                    acc[c] = syn_valid[c] && (q[c].size() < DEPTH);
                    if (syn_valid[c] && q[c].size() >= DEPTH) m_ovf = 1;
                end
                // The page owner, or the first waiting channel after the
                // last finished one.
                pick = owner;
                if (pick < 0) begin
                    for (int i = 1; i <= CH; i++) begin
                        if (pick < 0 && q[(rr + i) % CH].size() > 0) pick = (rr + i) % CH;
                    end
                end
                popd = 0;
                if (pick >= 0 && kes_avail && q[pick].size() > 0) begin
                    e    = q[pick].pop_front();
                    popd = 1;
                end
                m_exec = popd;
                if (popd) begin
                    m_syn   = e.syn;
                    m_chunk = e.chunk;
                    m_fwd   = !e.dec;
                    m_last  = e.last;
                    m_sel   = CHW'(pick);
                    owner   = e.last ? -1 : pick;
                    if (e.last) rr = pick;
                end else begin
                    owner = pick;
                end
                for (int c = 0; c < CH; c++) begin
                    if (acc[c]) begin
                        ne.syn   = dec_in[c] ? syn_in[c*SW +: SW] : '0;
                        ne.chunk = chunk_in[c*CW +: CW];
                        ne.dec   = dec_in[c];
                        ne.last  = last_in[c];
                        q[c].push_back(ne);
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        logic [CH-1:0] m_ready;
        forever begin
            @(negedge clk);
            if (started) begin
                for (int c = 0; c < CH; c++) m_ready[c] = (q[c].size() < DEPTH);
                chk("exec",     SW'(exec),      SW'(m_exec));
                chk("syn",      syn_out,        m_syn);
                chk("chunk",    SW'(chunk_out), SW'(m_chunk));
                chk("fwd",      SW'(fwd_out),   SW'(m_fwd));
                chk("last",     SW'(last_out),  SW'(m_last));
                chk("sel",      SW'(sel_out),   SW'(m_sel));
                chk("ready",    SW'(syn_ready), SW'(m_ready));
                chk("overflow", SW'(ovf),       SW'(m_ovf));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_in();
        syn_valid = '0;
        syn_in    = '0;
        chunk_in  = '0;
        dec_in    = '0;
        last_in   = '0;
    endtask

    task automatic put(input int c, input int chunk, input bit dec, input bit last, input int pat);
        syn_valid[c]           = 1'b1;
        syn_in[c*SW +: SW]     = {NS{12'(pat)}};
        chunk_in[c*CW +: CW]   = CW'(chunk);
        dec_in[c]              = dec;
        last_in[c]             = last;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        kes_avail = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        kes_avail = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_exec",  SW'(exec),      SW'(0));
        chk("rst_ready", SW'(syn_ready), SW'(4'hF));
        chk("rst_ovf",   SW'(ovf),       SW'(0));
        chk("rst_syn",   syn_out,        '0);
        chk("rst_sel",   SW'(sel_out),   SW'(0));

        // Two-chunk page on channel 0, continuous KES availability
        kes_avail = 1'b1;
        put(0, 0, 1, 0, 12'h101);
        step();
        chk("p1_exec_t1", SW'(exec), SW'(0));
        clear_in();
        put(0, 1, 1, 1, 12'h202);
        step();
        clear_in();
        chk("p1_exec_t2",  SW'(exec),      SW'(1));
        chk("p1_sel_t2",   SW'(sel_out),   SW'(0));
        chk("p1_last_t2",  SW'(last_out),  SW'(0));
        chk("p1_syn_t2",   syn_out,        {NS{12'h101}});
        step();
        chk("p1_exec_t3",  SW'(exec),      SW'(1));
        chk("p1_last_t3",  SW'(last_out),  SW'(1));
        chk("p1_chunk_t3", SW'(chunk_out), SW'(1));
        step();
        chk("p1_exec_t4",  SW'(exec),      SW'(0));

        // Channels 1 and 3 write one-chunk pages in the same cycle
        do_reset();
        kes_avail = 1'b1;
        put(1, 0, 1, 1, 12'h311);
        put(3, 1, 1, 1, 12'h333);
        step();
        clear_in();
        chk("rr_exec_t1", SW'(exec),    SW'(0));
        step();
        chk("rr_exec_t2", SW'(exec),    SW'(1));
        chk("rr_sel_t2",  SW'(sel_out), SW'(1));
        step();
        chk("rr_exec_t3", SW'(exec),    SW'(1));
        chk("rr_sel_t3",  SW'(sel_out), SW'(3));
        chk("rr_syn_t3",  syn_out,      {NS{12'h333}});

        // Channel 2 holds the lock while channel 0 waits
        do_reset();
        kes_avail = 1'b1;
        put(2, 0, 1, 0, 12'h420);
        step();
        clear_in();
        put(0, 0, 1, 1, 12'h400);
        step();
        clear_in();
        chk("lk_exec_s2", SW'(exec),    SW'(1));
        chk("lk_sel_s2",  SW'(sel_out), SW'(2));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lk_wait", SW'(exec), SW'(0));
        end
        put(2, 1, 1, 1, 12'h421);
        step();
        clear_in();
        chk("lk_exec_s6", SW'(exec),     SW'(0));
        step();
        chk("lk_exec_s7", SW'(exec),     SW'(1));
        chk("lk_sel_s7",  SW'(sel_out),  SW'(2));
        chk("lk_last_s7", SW'(last_out), SW'(1));
        step();
        chk("lk_exec_s8", SW'(exec),     SW'(1));
        chk("lk_sel_s8",  SW'(sel_out),  SW'(0));

        // Fill channel 0 with the KES stalled, then overflow
        do_reset();
        kes_avail = 1'b0;
        for (int k = 0; k < 5; k++) begin
            put(0, k % 2, 1, (k % 2) == 1, 12'h500 + k);
            step();
            if (k == 2) chk("ov_ready_3", SW'(syn_ready[0]), SW'(1));
            if (k == 3) begin
                chk("ov_ready_4", SW'(syn_ready[0]), SW'(0));
                chk("ov_ovf_4",   SW'(ovf),          SW'(0));
            end
        end
        clear_in();
        chk("ov_ovf_5", SW'(ovf), SW'(1));
        kes_avail = 1'b1;
        repeat (6) step();
        chk("ov_ovf_sticky", SW'(ovf),       SW'(1));
        chk("ov_drained",    SW'(syn_ready), SW'(4'hF));

        // Forward-only entry
        do_reset();
        kes_avail = 1'b1;
        put(3, 1, 0, 1, 12'hABC);
        step();
        clear_in();
        step();
        chk("fw_exec",  SW'(exec),      SW'(1));
        chk("fw_fwd",   SW'(fwd_out),   SW'(1));
        chk("fw_syn",   syn_out,        '0);
        chk("fw_sel",   SW'(sel_out),   SW'(3));
        chk("fw_chunk", SW'(chunk_out), SW'(1));

        // Reset while locked with two entries queued
        do_reset();
        kes_avail = 1'b0;
        put(1, 0, 1, 0, 12'h610);
        step();
        clear_in();
        put(1, 1, 1, 1, 12'h611);
        step();
        clear_in();
        step();
        chk("rl_exec_pre", SW'(exec), SW'(0));
        rst       = 1'b1;
        kes_avail = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("rl_exec_0",  SW'(exec),      SW'(0));
        chk("rl_ready",   SW'(syn_ready), SW'(4'hF));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rl_exec_n", SW'(exec), SW'(0));
        end

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shared_kes_syndrome_arbiter.md
SHARED_KES_SYNDROME_ARBITER -- requirements
Module: shared_kes_syndrome_arbiter

Interface
REQ-001 Parameter Channel, default 4: number of NAND channels sharing one KES engine, range 1..16.
REQ-002 Parameter Multi, default 2: chunks per page per channel; ChunkWidth = max(1, clog2(Multi)).
REQ-003 Parameter GaloisFieldDegree, default 12: bits per syndrome.
REQ-004 Parameter Syndromes, default 27: syndromes per chunk; SW = GaloisFieldDegree*Syndromes.
REQ-005 Parameter Depth, default 4: entries per per-channel FIFO, power of 2, >= 2; ChannelWidth = max(1, clog2(Channel)).
REQ-006 Ports:
- iClock  in  1  clock
- iReset  in  1  synchronous, active-high reset
- iSyndromeValid  in  Channel  per-channel chunk-entry valid
- oSyndromeReady  out  Channel  per-channel FIFO not full
- iSyndromes  in  Channel*SW  channel c at [(c+1)*SW-1 : c*SW]
- iChunkNumber  in  Channel*ChunkWidth  chunk index within page
- iDecodeNeeded  in  Channel  1 = chunk has errors
- iLastChunk  in  Channel  1 = last chunk of page
- iKESAvailable  in  1  KES can accept an entry this cycle
- oExecuteKES  out  1  one-cycle issue strobe
- oSyndromes  out  SW  issued syndromes
- oErroredChunkNumber  out  ChunkWidth  issued chunk index
- oDataForwarding  out  1  issued entry needs no decode (forward only)
- oLastChunk  out  1  issued entry closes the page
- oChannelSel  out  ChannelWidth  channel of issued entry
- oOverflow  out  1  sticky: valid seen while not ready

Function
REQ-007 Channel c SHALL write {syndromes, chunk, decodeNeeded, last} into its FIFO when iSyndromeValid[c] & oSyndromeReady[c]; entries with iDecodeNeeded=0 store zero syndromes.
REQ-008 oSyndromeReady[c] SHALL equal !full[c], independent of a same-cycle pop (no write-through when full).
REQ-009 Arbiter states: IDLE, LOCKED. IDLE: choose first non-empty channel round-robin starting at (last granted + 1) mod Channel, enter LOCKED same cycle.
REQ-010 LOCKED: pop head of granted FIFO in any cycle with iKESAvailable=1 and FIFO non-empty; stay LOCKED until an entry with last=1 is popped, then return to IDLE and update round-robin pointer.
REQ-011 LOCKED with empty granted FIFO SHALL wait; no other channel is served mid-page.
REQ-012 Popped entry SHALL be registered: outputs valid and oExecuteKES=1 exactly the cycle after the pop; oExecuteKES=0 otherwise; data outputs hold last value.
REQ-013 Latency: write at cycle t, earliest oExecuteKES at t+2.
REQ-014 Max throughput: one issued entry per cycle while iKESAvailable=1 continuously.
REQ-015 Simultaneous write and pop on one FIFO SHALL both occur; count unchanged.
REQ-016 FIFO pointers SHALL wrap modulo Depth; count width clog2(Depth+1).
REQ-017 oOverflow SHALL set when iSyndromeValid[c]=1 & oSyndromeReady[c]=0 for any c; cleared only by reset.

Reset
REQ-018 iReset SHALL flush all FIFOs, state=IDLE, round-robin pointer=Channel-1 (channel 0 first), oExecuteKES=0, all data outputs 0, oChannelSel=0, oOverflow=0, oSyndromeReady=all ones the cycle after reset deasserts.
REQ-019 Reset mid-page SHALL discard locked page; no oExecuteKES in the cycle following reset.

Structure
REQ-020 Shared package: ChunkWidth/ChannelWidth/SW derivation functions, arbiter state typedef {IDLE, LOCKED}, entry-struct field order.
REQ-021 One sub-module shared_kes_channel_fifo (per-channel synchronous FIFO, Depth x entry), instantiated Channel times by generate.

Verification
REQ-022 Ch0 writes 2 chunks (chunk 0 decode, chunk 1 last, decode), iKESAvailable=1 -> oExecuteKES at t+2 and t+3, oChannelSel=0, oLastChunk=1 on second.
REQ-023 Ch1 and ch3 each write 1-chunk page same cycle after reset -> ch1 issued first, ch3 next cycle.
REQ-024 Ch2 locked, sends chunk 0 only; ch0 page pending -> no ch0 issue until ch2 last chunk issued.
REQ-025 Depth=4, iKESAvailable=0, ch0 writes 5 entries -> oSyndromeReady[0]=0 after 4th, oOverflow=1 on 5th.
REQ-026 Entry with iDecodeNeeded=0 -> oDataForwarding=1, oSyndromes=0.
REQ-027 iReset during LOCKED with 2 queued entries -> no oExecuteKES after reset; oSyndromeReady all ones.
